// File: rtl/ps2_key_events_if.sv
// Byte-in / event-out bundle for the PS/2 key event decoder.
// The slave side is the decoder. The master side is the byte source and the event consumer.
interface ps2_key_events_if #(
  parameter int DEPTH = 8
);
  logic [7:0]              ps2_byte;
  logic                    ps2_valid;
  logic                    rd_en;
  logic [9:0]              evt_data;
  logic                    evt_valid;
  logic                    full;
  logic [$clog2(DEPTH):0]  count;
  logic                    overflow;
  logic [31:0]             disp;

  modport master (
    output ps2_byte, ps2_valid, rd_en,
    input  evt_data, evt_valid, full, count, overflow, disp
  );

  modport slave (
    input  ps2_byte, ps2_valid, rd_en,
    output evt_data, evt_valid, full, count, overflow, disp
  );
endinterface

// File: rtl/ps2_key_events.sv
// Turns PS/2 scan bytes into {ext, brk, code} key events.
// Events are queued in a first-word-fall-through FIFO, and the last four codes are kept for the display.
module ps2_key_events #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 2000000
) (
  input  logic            clk,
  input  logic            rst,
  ps2_key_events_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t        state, next_state;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          is_e0, is_f0, emit;
  logic [9:0]    emit_evt;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic [31:0]   disp_q;
  logic          empty, full_w, do_push, do_pop;

  assign is_e0    = (bus.ps2_byte == 8'hE0);
  assign is_f0    = (bus.ps2_byte == 8'hF0);
  assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT - 1));
  assign emit_evt = {(state == EXT) || (state == EXT_BRK),
                     (state == BRK) || (state == EXT_BRK),
                     bus.ps2_byte};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    emit       = 1'b0;
    if (bus.ps2_valid) begin
      case (state)
        IDLE: begin
          if (is_e0)      next_state = EXT;
          else if (is_f0) next_state = BRK;
          else            emit = 1'b1;
        end
        EXT: begin
          if (is_f0)      next_state = EXT_BRK;
          else if (!is_e0) begin
            emit       = 1'b1;
            next_state = IDLE;
          end
        end
        BRK: begin
          if (is_e0)      next_state = EXT_BRK;
          else if (!is_f0) begin
            emit       = 1'b1;
            next_state = IDLE;
          end
        end
        default: begin
          if (!is_e0 && !is_f0) begin
            emit       = 1'b1;
            next_state = IDLE;
          end
        end
      endcase
    end else if (state != IDLE && tmo_hit) begin
      next_state = IDLE;
    end
  end

  // Saturates at TIMEOUT-1, so it stays parked there in IDLE until the next byte clears it.
  always_ff @(posedge clk) begin
    if (rst)                            tmo_cnt <= '0;
    else if (bus.ps2_valid)             tmo_cnt <= '0;
    else if (state != IDLE && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign empty   = (count_q == '0);
  assign full_w  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = bus.rd_en && !empty;
  assign do_push = emit && (!full_w || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= emit_evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      disp_q     <= 32'h0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (emit && !do_push) overflow_q <= 1'b1;
      // The display history advances even when the FIFO drops the event.
      if (emit) disp_q <= {disp_q[23:0], bus.ps2_byte};
    end
  end

  assign bus.evt_data  = empty ? 10'h000 : mem[rd_ptr];
  assign bus.evt_valid = !empty;
  assign bus.full      = full_w;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.disp      = disp_q;
endmodule

// File: doc/ps2_key_events.md
# ps2_key_events

Decodes the raw byte stream from the PS/2 receiver into key events, buffers them in a small first-word-fall-through FIFO, and exposes a 32-bit history word for the display multiplexer. Each key event carries three fields: the scan code, an extended flag (E0 prefix) and a break flag (F0 prefix). It sits between the PS/2 receiver and the 8-channel display mux / downstream consumers, in the 100 MHz domain.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; must be a power of 2, at least 2.
- TIMEOUT, 2000000: idle cycles after which a pending prefix is abandoned (20 ms at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- ps2_byte  in  8  received scan byte; valid only while ps2_valid=1.
- ps2_valid  in  1  one-cycle strobe per received byte; may be asserted on consecutive cycles.
- rd_en  in  1  pop the head event; ignored when evt_valid=0.
- evt_data  out  10  head event {ext, brk, code[7:0]}; 10'h000 while FIFO empty.
- evt_valid  out  1  FIFO non-empty.
- full  out  1  FIFO holds DEPTH entries.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full; cleared only by rst.
- disp  out  32  last four decoded codes {c3,c2,c1,c0}; newest in [7:0].

## Operation
- Prefix FSM, states IDLE, EXT, BRK, EXT_BRK. Transitions happen only on cycles with ps2_valid=1, except for the timeout.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - Any other byte b -> emit {0,0,b}, stay in IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - E0 -> stay in EXT.
  - Any other byte b -> emit {1,0,b}, go to IDLE.
- BRK:
  - E0 -> EXT_BRK.
  - F0 -> stay in BRK.
  - Any other byte b -> emit {0,1,b}, go to IDLE.
- EXT_BRK:
  - E0 or F0 -> stay in EXT_BRK.
  - Any other byte b -> emit {1,1,b}, go to IDLE.
- Timeout:
  - Counter clears on every ps2_valid and counts while the FSM is not in IDLE.
  - When it reaches TIMEOUT-1 with no ps2_valid, the FSM returns to IDLE with no emit.
  - The counter saturates and does not run while in IDLE.
- Emit: push the event to the FIFO, and shift disp left by 8 with the code inserted at [7:0]. disp updates even when the push is dropped.
- FIFO: circular buffer with read/write pointers of width $clog2(DEPTH) that wrap modulo DEPTH; count is tracked explicitly.
  - Push and pop on the same cycle, FIFO non-empty and not full: both succeed, count unchanged.
  - Push and pop on the same cycle, FIFO full: both succeed, full stays 1, nothing dropped.
  - Push and pop on the same cycle, FIFO empty: the push succeeds and the pop is ignored, count becomes 1.
  - Push when full without a pop: the event is dropped, overflow is set, and the FIFO contents are unchanged.
  - Pop when empty: no effect.

## Timing
- Reset values: FSM = IDLE, timeout counter = 0, pointers = 0, count = 0, evt_valid = 0, full = 0, evt_data = 10'h000, overflow = 0, disp = 32'h0.
- Reset mid-sequence (pending prefix or FIFO partially full): all state returns to the reset values on that edge; stored events are lost.
- Latency: a non-prefix byte strobed at edge N is visible on evt_data/evt_valid, count, and disp after edge N (one cycle).
- evt_data is combinational from the head entry (FWFT). After a pop at edge N, the next entry is presented after edge N.
- Full throughput: one byte per cycle, one pop per cycle.
- rd_en and ps2_valid have no ordering constraint between them.

## Test plan
- Reset, then strobe 1C -> evt_data=10'h01C, evt_valid=1, count=1, disp=32'h0000001C. Then rd_en for one cycle -> evt_valid=0, evt_data=10'h000.
- Back-to-back strobes F0,1C, then E0,75, then E0,F0,75 on consecutive cycles -> FIFO pops in order 10'h11C, 10'h275, 10'h375; disp=32'h001C7575.
- Strobe E0, then wait TIMEOUT cycles, then strobe 1C -> single event 10'h01C, with no ext flag.
- With no pops, strobe 9 plain codes 01..09 (DEPTH=8) -> full=1, count=8, overflow=1; pops return 01..08; disp=32'h06070809.
- With FIFO full, strobe one code while asserting rd_en on the same cycle -> count stays 8, overflow stays 0, and the new code is last out.
- Strobe F0, then assert rst for one cycle, then strobe 1C -> event 10'h01C (break flag cleared); all reset values are checked on the cycle after rst.
